// File: rtl/instr_encoder_loader.sv
// Program loader: encodes instruction descriptors into RV32I words and
// writes them one after another into imem via a single write port.
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_fmt,
    input  logic [2:0]            in_funct3,
    input  logic                  in_funct7b5,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [20:0]           in_imm,
    input  logic                  in_last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_WRITE, S_DONE, S_ERROR
    } state_t;

    // encoder result: word plus the error code it would raise
    typedef struct packed {
        logic [31:0] word;
        logic [1:0]  err;
    } enc_t;

    // pointer and count carry one spare bit so they can reach the full capacity
    localparam logic [ADDR_WIDTH:0] BASE = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] CAP  = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH+1)'(1);

    state_t              st, nxt;
    enc_t                enc;
    logic                imm_bad, shift_op, i_ok, b_ok;
    logic                last_q;
    logic [ADDR_WIDTH:0] ptr;

    // immediate fits when the bits above the field are pure sign extension
    assign i_ok     = (in_imm[20:11] == '0) || (in_imm[20:11] == '1);
    assign b_ok     = ((in_imm[20:12] == '0) || (in_imm[20:12] == '1)) && !in_imm[0];
    assign shift_op = (in_funct3[1:0] == 2'b01);

    // combinational encode and legality check of the presented descriptor
    always_comb begin
        enc     = '0;
        imm_bad = 1'b0;
        case (in_fmt)
            3'd0: enc.word = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            3'd1: begin
                if (shift_op) begin
                    imm_bad  = (in_imm[20:5] != '0);
                    enc.word = {1'b0, in_funct7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                end else begin
                    imm_bad  = !i_ok;
                    enc.word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                end
            end
            3'd2: begin
                imm_bad  = !i_ok;
                enc.word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            end
            3'd3: begin
                imm_bad  = !i_ok;
                enc.word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            end
            3'd4: begin
                imm_bad  = !b_ok;
                enc.word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'b1100011};
            end
            3'd5: begin
                imm_bad  = !i_ok;
                enc.word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            end
            3'd6: begin
                imm_bad  = in_imm[0];
                enc.word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            end
            default: ;
        endcase
        // illegal format outranks immediate, which outranks overflow
        if (in_fmt == 3'd7)       enc.err = 2'b11;
        else if (imm_bad)         enc.err = 2'b01;
        else if (word_count == CAP) enc.err = 2'b10;
        else                      enc.err = 2'b00;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= S_IDLE;
        else     st <= nxt;
    end

    // next state: start always (re)opens a session
    always_comb begin
        nxt = st;
        if (start) begin
            nxt = S_ACCEPT;
        end else begin
            case (st)
                S_ACCEPT: if (in_valid) nxt = (enc.err != 2'b00) ? S_ERROR : S_WRITE;
                S_WRITE:  nxt = last_q ? S_DONE : S_ACCEPT;
                default:  ;
            endcase
        end
    end

    // outputs decoded from state; a start in WRITE kills that cycle's write
    always_comb begin
        in_ready = (st == S_ACCEPT);
        busy     = (st == S_ACCEPT) || (st == S_WRITE);
        imem_we  = (st == S_WRITE) && !start;
    end

    // datapath: capture on handshake, advance pointer after each write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= BASE;
            word_count <= '0;
            err        <= 2'b00;
            done       <= 1'b0;
            last_q     <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else if (start) begin
            ptr        <= BASE;
            word_count <= '0;
            err        <= 2'b00;
            done       <= 1'b0;
        end else begin
            case (st)
                S_ACCEPT: begin
                    if (in_valid) begin
                        if (enc.err != 2'b00) begin
                            err <= enc.err;
                        end else begin
                            imem_addr  <= ptr[ADDR_WIDTH-1:0];
                            imem_wdata <= enc.word;
                            last_q     <= in_last;
                        end
                    end
                end
                S_WRITE: begin
                    ptr        <= ptr + ONE;
                    word_count <= word_count + ONE;
                    if (last_q) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed plan vectors plus
// random descriptors scored against an arithmetic reference encoder.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_fmt = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7b5 = 1'b0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [20:0] in_imm = '0;
    logic        in_last = 1'b0;

    logic        rdy, we, busy, done;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  err;
    logic [8:0]  wc;

    logic        rdy2, we2, busy2, done2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic [1:0]  err2;
    logic [2:0]  wc2;

    int total = 0;
    int bad = 0;
    int cnt1 = 0;
    int cnt2 = 0;
    logic [1:0] last_e;

    localparam int CAP1 = 256;
    localparam int CAP2 = 4;

    always #5 clk = ~clk;

    instr_encoder_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy),
        .in_fmt(in_fmt), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .imem_we(we), .imem_addr(addr), .imem_wdata(wdata),
        .busy(busy), .done(done), .err(err), .word_count(wc)
    );

    instr_encoder_loader #(.ADDR_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy2),
        .in_fmt(in_fmt), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
        .busy(busy2), .done(done2), .err(err2), .word_count(wc2)
    );

    // reference encoder: integer range rules and shift/mask field placement
    function automatic logic [33:0] ref_enc(input logic [2:0] fmt, input logic [2:0] f3,
                                            input logic b5, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [20:0] imm);
        logic signed [20:0] s;
        int iv, r, w;
        logic [1:0] e;
        s = imm;
        iv = s;
        e = 2'b00;
        w = 0;
        r = (int'(rs1) << 15) | (int'(f3) << 12);
        case (fmt)
            3'd0: w = (int'(b5) << 30) | (int'(rs2) << 20) | r | (int'(rd) << 7) | 'h33;
            3'd1: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    if (iv < 0 || iv > 31) e = 2'b01;
                    w = (int'(b5) << 30) | ((iv & 31) << 20) | r | (int'(rd) << 7) | 'h13;
                end else begin
                    if (iv < -2048 || iv > 2047) e = 2'b01;
                    w = ((iv & 'hFFF) << 20) | r | (int'(rd) << 7) | 'h13;
                end
            end
            3'd2: begin
                if (iv < -2048 || iv > 2047) e = 2'b01;
                w = ((iv & 'hFFF) << 20) | r | (int'(rd) << 7) | 'h03;
            end
            3'd3: begin
                if (iv < -2048 || iv > 2047) e = 2'b01;
                w = (((iv >> 5) & 'h7F) << 25) | (int'(rs2) << 20) | r | ((iv & 31) << 7) | 'h23;
            end
            3'd4: begin
                if (iv < -4096 || iv > 4094 || (iv % 2) != 0) e = 2'b01;
                w = (((iv >> 12) & 1) << 31) | (((iv >> 5) & 63) << 25) | (int'(rs2) << 20) | r |
                    (((iv >> 1) & 15) << 8) | (((iv >> 11) & 1) << 7) | 'h63;
            end
            3'd5: begin
                if (iv < -2048 || iv > 2047) e = 2'b01;
                w = ((iv & 'hFFF) << 20) | (int'(rs1) << 15) | (int'(rd) << 7) | 'h67;
            end
            3'd6: begin
                if (iv < -1048576 || iv > 1048574 || (iv % 2) != 0) e = 2'b01;
                w = (((iv >> 20) & 1) << 31) | (((iv >> 1) & 'h3FF) << 21) | (((iv >> 11) & 1) << 20) |
                    (((iv >> 12) & 'hFF) << 12) | (int'(rd) << 7) | 'h6F;
            end
            default: e = 2'b11;
        endcase
        return {e, 32'(w)};
    endfunction

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt1 = 0;
        cnt2 = 0;
        total++;
        if ({rdy, busy, done, err, wc} !== {1'b1, 1'b1, 1'b0, 2'b00, 9'd0}) begin
            bad++;
            $display("FAIL start_state got rdy=%b busy=%b done=%b err=%b wc=%0d want 1 1 0 00 0",
                     rdy, busy, done, err, wc);
        end
    endtask

    // one handshake, then the write (or error) cycle and the cycle after it
    task automatic send(input logic [2:0] fmt, input logic [2:0] f3, input logic b5,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input int imm, input logic last, input bit chk2);
        logic [33:0] r;
        logic [31:0] w;
        logic [1:0]  e1, e2;
        r  = ref_enc(fmt, f3, b5, rd, rs1, rs2, 21'(imm));
        w  = r[31:0];
        e1 = r[33:32];
        e2 = e1;
        if (e1 == 2'b00 && cnt1 == CAP1) e1 = 2'b10;
        if (e2 == 2'b00 && cnt2 == CAP2) e2 = 2'b10;
        @(posedge clk); #1;
        in_valid = 1'b1; in_fmt = fmt; in_funct3 = f3; in_funct7b5 = b5;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = 21'(imm); in_last = last;
        total++;
        if (rdy !== 1'b1) begin
            bad++;
            $display("FAIL ready_in_accept got %b want 1", rdy);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (e1 == 2'b00) begin
            if ({we, addr, wdata, rdy} !== {1'b1, 8'(cnt1), w, 1'b0}) begin
                bad++;
                $display("FAIL write got we=%b addr=%0d wdata=%h rdy=%b want 1 %0d %h 0",
                         we, addr, wdata, rdy, cnt1, w);
            end
        end else if ({we, err, rdy, busy, wc} !== {1'b0, e1, 1'b0, 1'b0, 9'(cnt1)}) begin
            bad++;
            $display("FAIL error got we=%b err=%b rdy=%b busy=%b wc=%0d want 0 %b 0 0 %0d",
                     we, err, rdy, busy, wc, e1, cnt1);
        end
        if (chk2) begin
            total++;
            if (e2 == 2'b00) begin
                if ({we2, addr2, wdata2} !== {1'b1, 2'(cnt2), w}) begin
                    bad++;
                    $display("FAIL write2 got we=%b addr=%0d wdata=%h want 1 %0d %h",
                             we2, addr2, wdata2, cnt2, w);
                end
            end else if ({we2, err2, wc2, addr2} !== {1'b0, e2, 3'(cnt2), 2'(cnt2 - 1)}) begin
                bad++;
                $display("FAIL error2 got we=%b err=%b wc=%0d addr=%0d want 0 %b %0d %0d",
                         we2, err2, wc2, addr2, e2, cnt2, cnt2 - 1);
            end
        end
        last_e = e1;
        if (e1 == 2'b00 || (chk2 && e2 == 2'b00)) begin
            @(posedge clk); #1;
            if (e1 == 2'b00) begin
                cnt1++;
                total++;
                if ({we, wc, done} !== {1'b0, 9'(cnt1), last}) begin
                    bad++;
                    $display("FAIL post_write got we=%b wc=%0d done=%b want 0 %0d %b",
                             we, wc, done, cnt1, last);
                end
            end
            if (chk2 && e2 == 2'b00) begin
                cnt2++;
                total++;
                if ({we2, wc2} !== {1'b0, 3'(cnt2)}) begin
                    bad++;
                    $display("FAIL post_write2 got we=%b wc=%0d want 0 %0d", we2, wc2, cnt2);
                end
            end
        end
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({rdy, we, addr, wdata, busy, done, err, wc} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b we=%b addr=%h wdata=%h busy=%b done=%b err=%b wc=%0d want 0",
                     rdy, we, addr, wdata, busy, done, err, wc);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_r_add();
        do_start();
        send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 0, 1'b1, 1'b0);
        lit("r_add_word", wdata, 32'h002081B3);
        lit("r_add_done", {31'd0, done}, 32'd1);
        lit("r_add_count", 32'(wc), 32'd1);
    endtask

    task automatic test_back_to_back();
        do_start();
        send(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 0, 1'b0, 1'b0);
        lit("sub_word", wdata, 32'h402081B3);
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 5, 1'b1, 1'b0);
        lit("addi_word", wdata, 32'h00500093);
        lit("addi_addr", 32'(addr), 32'd1);
    endtask

    task automatic test_formats();
        do_start();
        send(3'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 8, 1'b0, 1'b0);
        lit("sw_word", wdata, 32'h0020A423);
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -4, 1'b0, 1'b0);
        lit("beq_word", wdata, 32'hFE208EE3);
        send(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 8, 1'b1, 1'b0);
        lit("jal_word", wdata, 32'h008000EF);
        lit("jal_addr", 32'(addr), 32'd2);
    endtask

    task automatic test_errors();
        do_start();
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 3, 1'b0, 1'b0);
        lit("odd_branch_err", 32'(err), 32'd1);
        do_start();
        send(3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 0, 1'b0, 1'b0);
        lit("illegal_err", 32'(err), 32'd3);
        do_start();
        send(3'd1, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32, 1'b0, 1'b0);
        lit("shamt_err", 32'(err), 32'd1);
        do_start();
    endtask

    task automatic test_overflow();
        do_start();
        for (int i = 0; i < 5; i++)
            send(3'd1, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, i, 1'b0, 1'b1);
        lit("ovf_err", 32'(err2), 32'd2);
        lit("ovf_count", 32'(wc2), 32'd4);
        lit("ovf_nowrap", 32'(addr2), 32'd3);
    endtask

    task automatic test_start_in_write();
        do_start();
        @(posedge clk); #1;
        in_valid = 1'b1; in_fmt = 3'd1; in_funct3 = 3'd0; in_rd = 5'd7; in_imm = 21'd9; in_last = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lit("abort_we_before", {31'd0, we}, 32'd1);
        start = 1'b1;
        #1;
        lit("abort_we_suppressed", {31'd0, we}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        cnt1 = 0;
        cnt2 = 0;
        lit("abort_state", {22'd0, rdy, wc}, {22'd0, 1'b1, 9'd0});
        send(3'd1, 3'd0, 1'b0, 5'd2, 5'd3, 5'd0, 100, 1'b1, 1'b0);
        lit("abort_addr", 32'(addr), 32'd0);
    endtask

    task automatic test_ignore();
        // loader is in DONE here; a descriptor must not be taken
        @(posedge clk); #1;
        in_valid = 1'b1; in_fmt = 3'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lit("ignore_idle", {21'd0, we, rdy, wc}, {21'd0, 1'b0, 1'b0, 9'd1});
    endtask

    task automatic test_async_reset();
        do_start();
        send(3'd1, 3'd0, 1'b0, 5'd5, 5'd6, 5'd0, 77, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({rdy, we, addr, wdata, busy, done, err, wc} !== '0) begin
            bad++;
            $display("FAIL async_reset got rdy=%b we=%b addr=%h wdata=%h busy=%b done=%b err=%b wc=%0d want 0",
                     rdy, we, addr, wdata, busy, done, err, wc);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] fmt, f3;
        int imm;
        logic last;
        do_start();
        for (int n = 0; n < 80; n++) begin
            fmt = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            f3  = 3'($urandom_range(0, 7));
            case (fmt)
                3'd1:    imm = (f3[1:0] == 2'b01) ? int'($urandom_range(0, 35))
                                                  : int'($urandom_range(0, 4399)) - 2200;
                3'd4:    imm = ((int'($urandom_range(0, 4199)) - 2100) * 2) + (($urandom_range(0, 9) == 0) ? 1 : 0);
                3'd6:    imm = (int'($urandom_range(0, 2097151)) - 1048576) & ~(($urandom_range(0, 9) == 0) ? 0 : 1);
                default: imm = int'($urandom_range(0, 4399)) - 2200;
            endcase
            last = ($urandom_range(0, 7) == 0);
            send(fmt, f3, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm, last, 1'b0);
            if (last_e != 2'b00 || last) do_start();
        end
    endtask

    initial begin
        test_reset();
        test_r_add();
        test_ignore();
        test_back_to_back();
        test_formats();
        test_errors();
        test_overflow();
        test_start_in_write();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the core's opcode decoder: accepts instruction descriptors and encodes each into a 32-bit RV32I word.
- The descriptor gives format class, funct fields, registers and a signed immediate.
- Each encoded word is written sequentially into instruction memory through a single-port write interface.
- Used as the on-chip program loader, between the host/test stimulus and imem, before the CPU is released from reset.

Parameters:
- ADDR_WIDTH, 8, imem word-address width; capacity 2^ADDR_WIDTH words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a load session; pointer := BASE_ADDR, count := 0
- in_valid  in  1  descriptor valid
- in_ready  out  1  loader can accept a descriptor
- in_fmt  in  3  0 R, 1 I-alu, 2 load, 3 store, 4 branch, 5 jalr, 6 jal, 7 illegal
- in_funct3  in  3  funct3 field
- in_funct7b5  in  1  instruction bit 30 (sub/sra); used for R and I-shift only
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  21  signed byte-offset / immediate
- in_last  in  1  final descriptor of the session
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  ADDR_WIDTH  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  session active (ACCEPT or WRITE)
- done  out  1  session completed without error; sticky until start/rst
- err  out  2  00 none, 01 immediate range/alignment, 10 address overflow, 11 illegal fmt; sticky
- word_count  out  ADDR_WIDTH+1  words written this session

Behaviour:
- Reset: state IDLE, all outputs 0. Internal pointer = BASE_ADDR.
- FSM states: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + start → ACCEPT. Clears err, done, word_count; pointer := BASE_ADDR.
- ACCEPT: in_ready=1, busy=1. Handshake in_valid&in_ready captures the descriptor and checks it in the same cycle.
  - Legal descriptor → WRITE.
  - Check failure → ERROR, err set, no write.
  - Error priority: fmt 7 (11) > immediate (01) > overflow (10).
- WRITE: in_ready=0. imem_we=1 for exactly one cycle with registered imem_addr/imem_wdata.
  - Then pointer+1, word_count+1.
  - Next state: DONE if captured in_last, else ACCEPT.
- Latency: handshake in cycle N → imem_we in cycle N+1. Throughput: one word per 2 cycles.
- imem_we is 0 in every state except WRITE. imem_addr/imem_wdata hold their last values otherwise.
- Encoding (opcodes):
  - R 0110011: funct7={0,funct7b5,00000}.
  - I-alu 0010011.
  - load 0000011.
  - store 0100011.
  - branch 1100011.
  - jalr 1100111, funct3 forced 000.
  - jal 1101111.
- Field placement: standard RV32I R/I/S/B/J layouts. Unused fields are 0; in_rs2 is ignored for I/J, in_rd for S/B.
- I-alu shifts (funct3 001/101): imm[11:5]={0,funct7b5,00000}, imm[4:0]=shamt. Shamt must be 0..31, else err 01.
- Immediate ranges:
  - I/load/jalr/store: -2048..2047.
  - branch: -4096..4094, must be even.
  - jal: -1048576..1048574, must be even.
  - Out of range or odd → err 01.
- Overflow: a descriptor accepted when word_count == 2^ADDR_WIDTH - (BASE_ADDR) → err 10, no write. The pointer never wraps.
- start while busy (any state, including WRITE): aborts the session. Any pending write in that cycle is suppressed (imem_we=0). Restarts as above.
- Asserting rst mid-session: immediate return to reset values. Partially loaded imem contents are not the block's concern.
- in_valid while not in ACCEPT: ignored, not captured.

Test Plan:
- start; R add rd=3 rs1=1 rs2=2 funct3=0, last=1 → imem_we one cycle after handshake, addr 0, wdata 0x002081B3. done=1, word_count=1.
- Same descriptor with funct7b5=1 → wdata 0x402081B3. Then I-alu addi rd=1 rs1=0 imm=5 → 0x00500093 at addr 1. Verify in_ready low during WRITE.
- store sw rs2=2 rs1=1 funct3=010 imm=8 → 0x0020A423. branch beq rs1=1 rs2=2 imm=-4 → 0xFE208EE3. jal rd=1 imm=8 → 0x008000EF. Addresses 0,1,2.
- Error cases, each as a separate session:
  - branch imm=3 → err=01, no imem_we, in_ready=0.
  - fmt=7 → err=11.
  - I-shift imm=32 → err=01.
  - A following start clears err.
- ADDR_WIDTH=2, 5 descriptors, none last → 4 writes to addr 0..3, 5th → err=10, word_count=4, no wrap.
- Assert start in a WRITE cycle → no imem_we that cycle, word_count=0, next descriptor written at BASE_ADDR. Assert rst asynchronously mid-ACCEPT → all outputs 0 immediately.
